// File: rtl/aes_round_controller_pkg.sv
// Shared types and constants for the AES-128 round sequencing control path.
package aes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KEY_EXP,
      INIT_ARK,
      ROUND,
      FINAL,
      DONE
   } aes_ctrl_state_t;

   localparam int AES128_ROUNDS = 10;
   localparam int ROUND_W       = 4;

endpackage

// File: rtl/aes_round_controller.sv
// Sequences one AES-128 encryption: optional key expansion, initial AddRoundKey,
// NUM_ROUNDS-1 full rounds and a final round, each preceded by KEY_LAT settle cycles.
module aes_round_controller
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES128_ROUNDS,
   parameter int KEY_LAT    = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               key_reload,
   input  logic               ke_done,
   output logic               ke_start,
   output logic [ROUND_W-1:0] round_number,
   output logic               load_state,
   output logic               round_en,
   output logic               last_round,
   output logic               busy,
   output logic               done
);

   // Handshakes are level/pulse based: start is taken only in IDLE or DONE;
   // ke_start is a one-cycle request and ke_done is honoured only in KEY_EXP.
   localparam int CNT_W = (KEY_LAT < 1) ? 1 : $clog2(KEY_LAT + 1);
   localparam logic [CNT_W-1:0]   LAT_C    = CNT_W'(KEY_LAT);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [ROUND_W-1:0] LAST_R   = ROUND_W'(NUM_ROUNDS);
   localparam logic [ROUND_W-1:0] PENULT_R = ROUND_W'(NUM_ROUNDS - 1);
   localparam logic [ROUND_W-1:0] RN_ONE   = ROUND_W'(1);
   localparam logic               LAT_ZERO = (KEY_LAT == 0);
   localparam logic               ONE_RND  = (NUM_ROUNDS == 1);

   aes_ctrl_state_t  state;
   logic             keys_ready;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         keys_ready   <= 1'b0;
         cnt          <= '0;
         round_number <= '0;
         ke_start     <= 1'b0;
         load_state   <= 1'b0;
         round_en     <= 1'b0;
         last_round   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         ke_start   <= 1'b0;
         load_state <= 1'b0;
         round_en   <= 1'b0;
         last_round <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  cnt          <= '0;
                  round_number <= '0;
                  if (key_reload || !keys_ready) begin
                     state    <= KEY_EXP;
                     ke_start <= 1'b1;
                  end else begin
                     state      <= INIT_ARK;
                     load_state <= LAT_ZERO;
                  end
               end
            end
            KEY_EXP: begin
               if (ke_done) begin
                  keys_ready <= 1'b1;
                  state      <= INIT_ARK;
                  cnt        <= '0;
                  load_state <= LAT_ZERO;
               end
            end
            INIT_ARK: begin
               if (cnt == LAT_C) begin
                  cnt          <= '0;
                  round_number <= RN_ONE;
                  state        <= ONE_RND ? FINAL : ROUND;
                  round_en     <= LAT_ZERO;
                  last_round   <= LAT_ZERO && ONE_RND;
               end else begin
                  cnt        <= cnt + CNT_ONE;
                  load_state <= ((cnt + CNT_ONE) == LAT_C);
               end
            end
            ROUND: begin
               if (cnt == LAT_C) begin
                  cnt      <= '0;
                  round_en <= LAT_ZERO;
                  if (round_number == PENULT_R) begin
                     state        <= FINAL;
                     round_number <= LAST_R;
                     last_round   <= LAT_ZERO;
                  end else begin
                     round_number <= round_number + RN_ONE;
                  end
               end else begin
                  cnt      <= cnt + CNT_ONE;
                  round_en <= ((cnt + CNT_ONE) == LAT_C);
               end
            end
            FINAL: begin
               if (cnt == LAT_C) begin
                  cnt   <= '0;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt        <= cnt + CNT_ONE;
                  round_en   <= ((cnt + CNT_ONE) == LAT_C);
                  last_round <= ((cnt + CNT_ONE) == LAT_C);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench for aes_round_controller: a KEY_LAT=0 and a KEY_LAT=2 instance,
// each checked every cycle against a timeline model of one encryption.
module tb_aes_round_controller;

   localparam int NUM = 10;
   localparam int M_IDLE = 0, M_KEXP = 1, M_RUN = 2, M_DONE = 3;

   logic clk;
   logic rst [2];
   logic start [2];
   logic key_reload [2];
   logic ke_auto [2];
   logic ke_force [2];
   logic ke_done [2];
   logic ke_start_o [2];
   logic load_o [2];
   logic ren_o [2];
   logic last_o [2];
   logic busy_o [2];
   logic done_o [2];
   logic [3:0] rn_o [2];

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   int mode [2]   = '{M_IDLE, M_IDLE};
   int t [2]      = '{0, 0};
   bit keys [2]   = '{1'b0, 1'b0};
   bit kfirst [2] = '{1'b0, 1'b0};
   int lat [2]    = '{0, 2};
   int kcnt [2]   = '{0, 0};
   int ke_cnt [2] = '{0, 0};

   assign ke_done[0] = ke_auto[0] | ke_force[0];
   assign ke_done[1] = ke_auto[1] | ke_force[1];

   aes_round_controller dut0 (
      .clk(clk), .reset(rst[0]), .start(start[0]), .key_reload(key_reload[0]),
      .ke_done(ke_done[0]), .ke_start(ke_start_o[0]), .round_number(rn_o[0]),
      .load_state(load_o[0]), .round_en(ren_o[0]), .last_round(last_o[0]),
      .busy(busy_o[0]), .done(done_o[0])
   );

   aes_round_controller #(.KEY_LAT(2)) dut1 (
      .clk(clk), .reset(rst[1]), .start(start[1]), .key_reload(key_reload[1]),
      .ke_done(ke_done[1]), .ke_start(ke_start_o[1]), .round_number(rn_o[1]),
      .load_state(load_o[1]), .round_en(ren_o[1]), .last_round(last_o[1]),
      .busy(busy_o[1]), .done(done_o[1])
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ke_done stub: answers each ke_start five cycles later
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ke_start_o[k] === 1'b1) begin
            ke_cnt[k]++;
            kcnt[k]    = 5;
            ke_auto[k] = 1'b0;
         end else if (kcnt[k] > 0) begin
            kcnt[k]--;
            ke_auto[k] = (kcnt[k] == 0);
         end else begin
            ke_auto[k] = 1'b0;
         end
      end
   end

   // model advance on each edge, then compare all outputs just after it
   always @(posedge clk) begin
      int total;
      int slot;
      int sub;
      bit fire;
      logic [9:0] exp_v;
      logic [9:0] act_v;
      logic [9:0] mask;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         total = (NUM + 1) * (lat[k] + 1);
         if (rst[k]) begin
            mode[k] = M_IDLE;
            keys[k] = 1'b0;
         end else begin
            case (mode[k])
               M_IDLE, M_DONE: if (start[k]) begin
                  if (key_reload[k] || !keys[k]) begin
                     mode[k]   = M_KEXP;
                     kfirst[k] = 1'b1;
                  end else begin
                     mode[k] = M_RUN;
                     t[k]    = 0;
                  end
               end
               M_KEXP: begin
                  kfirst[k] = 1'b0;
                  if (ke_done[k]) begin
                     keys[k] = 1'b1;
                     mode[k] = M_RUN;
                     t[k]    = 0;
                  end
               end
               default: begin
                  t[k]++;
                  if (t[k] == total) mode[k] = M_DONE;
               end
            endcase
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         mask = 10'h3ff;
         case (mode[k])
            M_IDLE: exp_v = 10'b0;
            M_DONE: exp_v = {6'b000001, 4'(NUM)};
            M_KEXP: begin
               exp_v = {kfirst[k], 5'b00010, 4'b0};
               mask  = 10'h3f0;
            end
            default: begin
               slot  = t[k] / (lat[k] + 1);
               sub   = t[k] % (lat[k] + 1);
               fire  = (sub == lat[k]);
               exp_v = {1'b0, fire && slot == 0, fire && slot > 0, fire && slot == NUM,
                        2'b10, 4'(slot)};
            end
         endcase
         act_v = {ke_start_o[k], load_o[k], ren_o[k], last_o[k], busy_o[k], done_o[k], rn_o[k]};
         vectors++;
         if ((act_v & mask) !== (exp_v & mask)) begin
            errors++;
            $display("FAIL cycle_outputs dut%0d cycle %0d: got %b expected %b (mask %b)",
                     k, cyc, act_v, exp_v, mask);
         end
      end
   end

   // driver: start an encryption in cycle 0 and disturb it at chosen cycles
   task automatic run_enc(input int k, input bit reload, input int kd_at, input int st_at,
                          input int rst_at, input int hold_to, output int n);
      @(negedge clk);
      start[k]      = 1'b1;
      key_reload[k] = reload;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check("done_low_after_start", int'(done_o[k]), 0);
         start[k]      = (n < hold_to) || (n == st_at);
         key_reload[k] = (n == st_at) ? 1'b1 : reload;
         ke_force[k]   = (n == kd_at);
         rst[k]        = (n == rst_at);
      end while (!(done_o[k] === 1'b1 && n > hold_to) && !(rst_at > 0 && n == rst_at + 1)
                 && n < 300);
      start[k]    = 1'b0;
      ke_force[k] = 1'b0;
      rst[k]      = 1'b0;
   endtask

   initial begin
      int n;
      int kc;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; start[k] = 1'b0; key_reload[k] = 1'b0; ke_force[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy_o[0]), 0);
      check("reset_done", int'(done_o[0]), 0);
      check("reset_round_number", int'(rn_o[0]), 0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      repeat (2) @(negedge clk);

      run_enc(0, 1'b1, 0, 0, 0, 1, n);
      check("first_run_done_latency", n, 18);
      check("first_run_ke_starts", ke_cnt[0], 1);
      repeat (4) @(negedge clk);
      check("done_holds", int'(done_o[0]), 1);

      run_enc(0, 1'b0, 0, 0, 0, 1, n);
      check("reuse_done_latency", n, 12);
      check("reuse_no_ke_start", ke_cnt[0], 1);

      run_enc(0, 1'b0, 6, 5, 0, 1, n);
      check("disturbed_done_latency", n, 12);
      check("disturbed_no_ke_start", ke_cnt[0], 1);

      run_enc(0, 1'b0, 0, 0, 0, 13, n);
      check("held_start_restart_latency", n, 24);

      run_enc(0, 1'b0, 0, 0, 7, 1, n);
      check("mid_reset_busy", int'(busy_o[0]), 0);
      check("mid_reset_round_number", int'(rn_o[0]), 0);
      check("mid_reset_round_en", int'(ren_o[0]), 0);
      kc = ke_cnt[0];
      run_enc(0, 1'b0, 0, 0, 0, 1, n);
      check("after_reset_ke_start", ke_cnt[0], kc + 1);
      check("after_reset_done_latency", n, 18);

      run_enc(0, 1'b1, 1, 0, 0, 1, n);
      check("ke_done_on_entry_latency", n, 13);
      repeat (8) @(negedge clk);

      run_enc(1, 1'b1, 0, 0, 0, 1, n);
      check("lat2_expand_done_latency", n, 40);
      run_enc(1, 1'b0, 0, 0, 0, 1, n);
      check("lat2_reuse_done_latency", n, 34);

      @(negedge clk);
      rst[1]   = 1'b1;
      start[1] = 1'b1;
      @(negedge clk);
      rst[1]   = 1'b0;
      start[1] = 1'b0;
      check("reset_beats_start_busy", int'(busy_o[1]), 0);
      check("reset_beats_start_ke_start", int'(ke_start_o[1]), 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/aes_round_controller.md
Name: aes_round_controller

Overview:
- Control FSM that sequences one AES-128 encryption.
- Starts the key_expansion block and waits for its done.
- Then steps round_number 0..10 into key_expansion and issues per-round enables to the cipher state datapath (initial AddRoundKey, 9 full rounds, final round without MixColumns).
- Sits between the top-level SPI/load logic and the key_expansion + round datapath; contains no datapath itself.

Parameters:
- NUM_ROUNDS, 10: total cipher rounds after the initial AddRoundKey (AES-128).
- KEY_LAT, 0: settle cycles per round. round_number is held and no enable is asserted during these cycles before the round's enable pulse (covers registered round-key lookup).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  request one encryption; sampled in IDLE and DONE only
- key_reload  input  1  sampled with start: 1 = re-run key expansion, 0 = reuse keys if already expanded since reset
- ke_done  input  1  key_expansion finished; sampled only in KEY_EXP
- ke_start  output  1  one-cycle pulse to key_expansion start
- round_number  output  4  round-key index driven to key_expansion
- load_state  output  1  one-cycle: state <= plaintext ^ round_key(0)
- round_en  output  1  one-cycle: apply SubBytes/ShiftRows/MixColumns/AddRoundKey
- last_round  output  1  qualifies round_en: skip MixColumns
- busy  output  1  high in every state except IDLE and DONE
- done  output  1  high while in DONE; cleared on accepted start or reset

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state IDLE; all outputs 0; round_number 0.
  - keys_ready flag 0; settle counter 0.
- FSM states: IDLE, KEY_EXP, INIT_ARK, ROUND, FINAL, DONE.
- IDLE/DONE, start=1:
  - done cleared next cycle.
  - If key_reload=1 or keys_ready=0: go to KEY_EXP.
  - Otherwise: go to INIT_ARK.
- KEY_EXP:
  - ke_start=1 only on the first cycle in the state.
  - Stay until ke_done=1. ke_done on the entry cycle counts.
  - On exit: set keys_ready=1 and go to INIT_ARK.
- INIT_ARK:
  - round_number=0.
  - KEY_LAT settle cycles, then one cycle with load_state=1.
  - Then go to ROUND with round_number=1.
- ROUND:
  - For r = 1..NUM_ROUNDS-1: round_number=r; KEY_LAT settle cycles, then one cycle round_en=1.
  - round_number increments on the cycle after round_en.
  - After r = NUM_ROUNDS-1: go to FINAL.
- FINAL:
  - round_number=NUM_ROUNDS; KEY_LAT settle cycles, then one cycle round_en=1 with last_round=1.
  - Then go to DONE.
- DONE:
  - done=1 and busy=0; round_number holds NUM_ROUNDS.
  - Stays until start.
- Latency with KEY_LAT=0 and key reuse: start sampled at edge 0.
  - INIT_ARK occupies cycle 1, rounds occupy cycles 2..11.
  - done=1 from cycle 12.
  - General: done asserts 1 + (NUM_ROUNDS+1)*(KEY_LAT+1) cycles after start, plus KEY_EXP time when expanding.
- Boundary conditions:
  - start while busy: ignored, no side effects.
  - start held high across DONE: restarts immediately; done is low for that run.
  - ke_done outside KEY_EXP: ignored.
  - Reset mid-operation: next cycle is IDLE with all outputs 0 and keys_ready=0.
  - Reset and start in the same cycle: reset wins.
  - load_state, round_en and ke_start are mutually exclusive in every cycle.
  - last_round=1 only when round_en=1.
  - round_number never exceeds NUM_ROUNDS.
  - Settle counter is width $clog2(KEY_LAT+1), minimum 1 bit; it clears on every state change.

Decomposition:
- aes_pkg:
  - typedef enum logic [2:0] aes_ctrl_state_t {IDLE, KEY_EXP, INIT_ARK, ROUND, FINAL, DONE}.
  - localparam AES128_ROUNDS = 10.
  - localparam ROUND_W = 4.
- No sub-module: a single FSM with round counter and settle counter. The counter logic is too small to justify splitting.

Test Plan:
- Reset, then start=1 with key_reload=1; ke_done stub asserts 5 cycles after ke_start -> ke_start pulses once; load_state pulses with round_number=0; round_en pulses at round_number 1..10 on consecutive cycles; last_round only at 10; done rises and stays.
- Second start with key_reload=0 after the first run -> no ke_start; done exactly 12 cycles after start (KEY_LAT=0); done low on the cycle after start.
- KEY_LAT=2 build, key reuse -> each round_number value held 3 cycles with the enable on the 3rd; done 34 cycles after start.
- start pulsed at round 4 and ke_done pulsed in ROUND -> sequence unchanged; no extra ke_start; done timing identical to the undisturbed run.
- reset asserted at round 6 -> next cycle all outputs 0, busy=0; subsequent start with key_reload=0 still issues ke_start (keys_ready cleared).
- Integrate with key_expansion on key 2b7e151628aed2a6abf7158809cf4f3c:
  - round key at round_number 1 = a0fafe1788542cb123a339392a6c7605.
  - round key at round_number 2 = f2c295f27a96b9435935807a7359f67f.
  - round key at round_number 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
